// File: rtl/prog_loader.sv
// Program loader: receives a length byte followed by instr/arg byte pairs
// over a valid/ready stream and emits one write strobe per word into program memory.
module prog_loader #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             we,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] arg,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        INSTR,
        ARG,
        WRITE,
        FIN
    } state_t;

    // One extra bit so both the length and the word count can represent SIZE itself.
    localparam logic [WIDTH:0] SIZE_W = (WIDTH + 1)'(SIZE);

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH:0] cnt;
    logic [WIDTH:0] cnt_inc;
    logic [WIDTH:0] n_len;
    logic [WIDTH:0] len_in;
    logic           accept;
    logic           len_bad;

    assign accept  = byte_ready && byte_valid;
    assign cnt_inc = cnt + 1'b1;
    assign len_in  = {1'b0, byte_in};
    assign len_bad = len_in > SIZE_W;

    // Handshake and strobes decode from the registered state only, so byte_ready
    // never depends combinationally on byte_valid.
    assign byte_ready = (state == LEN) || (state == INSTR) || (state == ARG);
    assign we         = (state == WRITE);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; combinational logic below uses blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                if (accept) begin
                    if (byte_in == '0)  state_nxt = FIN;
                    else if (len_bad)   state_nxt = IDLE;
                    else                state_nxt = INSTR;
                end
            end
            INSTR: begin
                if (accept) state_nxt = ARG;
            end
            ARG: begin
                if (accept) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = (cnt_inc == n_len) ? FIN : INSTR;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            instr <= '0;
            arg   <= '0;
            cnt   <= '0;
            n_len <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        addr <= '0;
                        cnt  <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        n_len <= len_in;
                        if (len_bad) err <= 1'b1;
                    end
                end
                INSTR: begin
                    if (accept) instr <= byte_in;
                end
                ARG: begin
                    if (accept) arg <= byte_in;
                end
                WRITE: begin
                    // addr ends up equal to the number of words written once FIN is reached.
                    addr <= addr + 1'b1;
                    cnt  <= cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random program images streamed with
// optional stalls, compared against a list-of-writes model built from the byte stream.
module tb_prog_loader;

    localparam int W = 8;
    localparam int S = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] instr;
    logic [W-1:0] arg;
    logic         busy;
    logic         done;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3*W-1:0] wq[$];
    int             done_cnt;
    int             we_cnt;

    prog_loader #(.WIDTH(W), .SIZE(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .addr       (addr),
        .instr      (instr),
        .arg        (arg),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Monitor: record every write and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (we) begin
            wq.push_back({addr, instr, arg});
            we_cnt++;
        end
        if (done) done_cnt++;
    end

    // Streams one load: length byte then 2*len random bytes (or junk if len is
    // out of range). exp_cycles < 0 skips the latency comparison.
    task automatic run_load(input logic [W-1:0] len, input bit stall,
                            input bit pulse_start, input int exp_cycles);
        logic [W-1:0]   bytes[$];
        logic [3*W-1:0] exp_w[$];
        logic [3*W-1:0] got;
        bit             ok_len;
        int             nbytes;
        int             idx;
        int             cyc;
        ok_len = (int'(len) <= S);
        bytes.delete();
        bytes.push_back(len);
        nbytes = ok_len ? 2 * int'(len) : 4;
        for (int i = 0; i < nbytes; i++) bytes.push_back(W'($urandom));
        exp_w.delete();
        if (ok_len)
            for (int i = 0; i < int'(len); i++)
                exp_w.push_back({W'(i), bytes[1 + 2 * i], bytes[2 + 2 * i]});
        wq.delete();
        done_cnt = 0;

        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            if (idx < bytes.size()) begin
                byte_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                byte_in    = bytes[idx];
            end else begin
                byte_valid = 1'b0;
                byte_in    = W'($urandom);
            end
            if (byte_valid && byte_ready) idx++;
            start = pulse_start && (cyc == 10 || cyc == 40);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        start      = 1'b0;

        n_checks++;
        if (cyc >= 1000) begin
            n_fail++;
            $display("FAIL load_timeout len=%0d: still busy after %0d cycles", len, cyc);
        end
        if (exp_cycles >= 0) begin
            n_checks++;
            if (cyc !== exp_cycles) begin
                n_fail++;
                $display("FAIL latency len=%0d: got %0d cycles, expected %0d", len, cyc, exp_cycles);
            end
        end
        n_checks++;
        if (err !== !ok_len) begin
            n_fail++;
            $display("FAIL err len=%0d: got %b, expected %b", len, err, !ok_len);
        end
        n_checks++;
        if (done_cnt !== int'(ok_len)) begin
            n_fail++;
            $display("FAIL done_pulses len=%0d: got %0d, expected %0d", len, done_cnt, int'(ok_len));
        end
        n_checks++;
        if (wq.size() !== exp_w.size()) begin
            n_fail++;
            $display("FAIL write_count len=%0d: got %0d, expected %0d", len, wq.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && wq.size() > 0; i++) begin
            got = wq.pop_front();
            n_checks++;
            if (got !== exp_w[i]) begin
                n_fail++;
                $display("FAIL write[%0d] len=%0d: got addr/instr/arg %h, expected %h", i, len, got, exp_w[i]);
            end
        end
        n_checks++;
        if (addr !== (ok_len ? len : W'(0))) begin
            n_fail++;
            $display("FAIL final_addr len=%0d: got %0d, expected %0d", len, addr, ok_len ? len : W'(0));
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h5A;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({byte_ready, we, busy, done, err, addr, instr, arg} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy/we/busy/done/err=%b%b%b%b%b addr=%h instr=%h arg=%h, expected all 0",
                     byte_ready, we, busy, done, err, addr, instr, arg);
        end
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b, expected 0", busy);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < 3; k++) run_load(W'(2), 1'b0, 1'b0, 8);
        run_load(W'(1), 1'b0, 1'b0, 5);
        run_load(W'($urandom_range(3, 12)), 1'b0, 1'b0, -1);
    endtask

    task automatic test_zero_len();
        run_load(W'(0), 1'b0, 1'b0, 2);
    endtask

    task automatic test_bad_len();
        run_load(W'(33), 1'b0, 1'b0, 1);
        run_load(W'($urandom_range(S + 1, 255)), 1'b0, 1'b0, 1);
        // A following good load must clear the sticky error.
        run_load(W'(2), 1'b0, 1'b0, 8);
    endtask

    task automatic test_stall();
        run_load(W'(1), 1'b1, 1'b0, -1);
        run_load(W'($urandom_range(2, 8)), 1'b1, 1'b0, -1);
    endtask

    task automatic test_full();
        run_load(W'(S), 1'b0, 1'b1, 2 + 3 * S);
        run_load(W'(S), 1'b1, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] bytes[7];
        int idx;
        int cyc;
        bytes[0] = W'(3);
        for (int i = 1; i < 7; i++) bytes[i] = W'($urandom);
        we_cnt   = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        // Length, instr0, arg0 and instr1 consumed means the loader now waits in ARG of word 1.
        while (!(idx == 4 && byte_ready) && cyc < 100) begin
            cyc++;
            byte_valid = 1'b1;
            byte_in    = bytes[idx];
            if (byte_ready) idx++;
            @(negedge clk);
        end
        byte_in = bytes[4];
        rst     = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        byte_valid = 1'b0;
        n_checks++;
        if ({byte_ready, we, busy, done, err, addr, instr, arg} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy/we/busy/done/err=%b%b%b%b%b addr=%h instr=%h arg=%h, expected all 0",
                     byte_ready, we, busy, done, err, addr, instr, arg);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (we_cnt !== 1) begin
            n_fail++;
            $display("FAIL mid_reset_writes: got %0d we pulses, expected 1", we_cnt);
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_done: got %0d done pulses, expected 0", done_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = '0;
        done_cnt   = 0;
        we_cnt     = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_bad_len();
        test_stall();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
